// File: rtl/ahb_slave_arbiter_pkg.sv
//----------------------------------------------------------------------------
// Module  : ahb_slave_arbiter_pkg
// Brief   : Shared types, default constants and helpers for the slave arbiter.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package ahb_slave_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_FIXED = 2'd0,
      ARB_RR    = 2'd1,
      ARB_DYN   = 2'd2
   } arb_mode_e;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_e;

   localparam int c_master_num_dflt = 4;
   localparam int c_prior_bit_dflt  = 2;
   localparam int c_max_hold_dflt   = 16;

   // Up to 16 masters; OR-accumulation is exact for one-hot or zero input.
   function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (oh[i]) begin
            idx = idx | 4'(i);
         end
      end
      return idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_slave_arbiter_if.sv
//----------------------------------------------------------------------------
// Module  : ahb_slave_arbiter_if
// Brief   : Request/grant bundle between the masters and one slave arbiter.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface ahb_slave_arbiter_if
   import ahb_slave_arbiter_pkg::*;
#(
   parameter int MASTER_NUM = c_master_num_dflt,
   parameter int PRIOR_BIT  = c_prior_bit_dflt
) ();

   localparam int c_iw = $clog2(MASTER_NUM);

   logic [MASTER_NUM-1:0]           hreq;
   logic [MASTER_NUM-1:0]           hlast;
   logic                            hwait;
   logic [MASTER_NUM*PRIOR_BIT-1:0] hprior;
   logic [MASTER_NUM-1:0]           hgrant;
   logic [c_iw-1:0]                 hmaster;
   logic                            hsel;
   logic                            hforce;

   modport master (
      output hreq, hlast, hwait, hprior,
      input  hgrant, hmaster, hsel, hforce
   );

   modport slave (
      input  hreq, hlast, hwait, hprior,
      output hgrant, hmaster, hsel, hforce
   );

endinterface

`default_nettype wire

// File: rtl/ahb_slave_arbiter_pick.sv
//----------------------------------------------------------------------------
// Module  : arb_pick
// Brief   : Combinational winner picker (fixed, rotating or priority+rotating).
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module arb_pick
   import ahb_slave_arbiter_pkg::*;
#(
   parameter int MASTER_NUM = c_master_num_dflt,
   parameter int PRIOR_BIT  = c_prior_bit_dflt
) (
   input  logic [MASTER_NUM-1:0]           req,
   input  logic [MASTER_NUM-1:0]           mask,
   input  logic [$clog2(MASTER_NUM)-1:0]   start,
   input  logic [MASTER_NUM*PRIOR_BIT-1:0] prior,
   input  arb_mode_e                       mode,
   output logic                            found,
   output logic [$clog2(MASTER_NUM)-1:0]   winner
);

   localparam int c_iw = $clog2(MASTER_NUM);

   logic [MASTER_NUM-1:0] w_elig;
   logic [MASTER_NUM-1:0] w_top;
   logic [MASTER_NUM-1:0] w_cand;
   logic [PRIOR_BIT-1:0]  w_max;
   logic [c_iw-1:0]       w_fix_idx;
   logic                  w_hi_found;
   logic [c_iw-1:0]       w_hi_idx;
   logic [c_iw-1:0]       w_lo_idx;

   assign w_elig = req & ~mask;
   assign found  = |w_elig;

   always_comb begin : p_max
      w_max = '0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         if (w_elig[i] && (prior[i*PRIOR_BIT +: PRIOR_BIT] > w_max)) begin
            w_max = prior[i*PRIOR_BIT +: PRIOR_BIT];
         end
      end
   end

   generate
      for (genvar g = 0; g < MASTER_NUM; g++) begin : g_top
         assign w_top[g] = w_elig[g] && (prior[g*PRIOR_BIT +: PRIOR_BIT] == w_max);
      end
   endgenerate

   assign w_cand = (mode == ARB_DYN) ? w_top : w_elig;

   // Descending scans leave the lowest matching index in each result.
   always_comb begin : p_scan
      w_fix_idx  = '0;
      w_hi_found = 1'b0;
      w_hi_idx   = '0;
      w_lo_idx   = '0;
      for (int i = MASTER_NUM-1; i >= 0; i--) begin
         if (w_elig[i]) begin
            w_fix_idx = c_iw'(i);
         end
         if (w_cand[i]) begin
            w_lo_idx = c_iw'(i);
            if (c_iw'(i) >= start) begin
               w_hi_found = 1'b1;
               w_hi_idx   = c_iw'(i);
            end
         end
      end
   end

   // Rotating search: first candidate at or above start, else wrap to the lowest.
   assign winner = (mode == ARB_FIXED) ? w_fix_idx :
                   (w_hi_found ? w_hi_idx : w_lo_idx);

endmodule

`default_nettype wire

// File: rtl/ahb_slave_arbiter.sv
//----------------------------------------------------------------------------
// Module  : ahb_slave_arbiter
// Brief   : Per-slave burst-holding arbiter with rotation and hold watchdog.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module ahb_slave_arbiter
   import ahb_slave_arbiter_pkg::*;
#(
   parameter int        MASTER_NUM = c_master_num_dflt,
   parameter int        PRIOR_BIT  = c_prior_bit_dflt,
   parameter arb_mode_e ARB_MODE   = ARB_RR,
   parameter int        MAX_HOLD   = c_max_hold_dflt
) (
   input  logic               hclk,
   input  logic               hreset,
   ahb_slave_arbiter_if.slave bus
);

   localparam int                 c_iw       = $clog2(MASTER_NUM);
   localparam int                 c_hw       = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [c_hw-1:0]    c_max_hold = c_hw'(MAX_HOLD);
   localparam logic [c_iw-1:0]    c_last_idx = c_iw'(MASTER_NUM - 1);

   arb_state_e            r_state,    w_state_nxt;
   logic [MASTER_NUM-1:0] r_grant,    w_grant_nxt;
   logic                  r_hsel,     w_hsel_nxt;
   logic                  r_hforce,   w_hforce_nxt;
   logic [c_iw-1:0]       r_rr_ptr,   w_rr_ptr_nxt;
   logic [c_hw-1:0]       r_hold_cnt, w_hold_cnt_nxt;

   logic                  w_owner_req;
   logic                  w_owner_last;
   logic                  w_watchdog;
   logic                  w_release;
   logic                  w_take;
   logic [MASTER_NUM-1:0] w_mask;
   logic                  w_found;
   logic [c_iw-1:0]       w_winner;
   logic [MASTER_NUM-1:0] w_winner_oh;
   logic [c_iw-1:0]       w_ptr_after;

   assign w_owner_req  = |(bus.hreq  & r_grant);
   assign w_owner_last = |(bus.hlast & r_grant);
   assign w_watchdog   = (MAX_HOLD != 0) && (r_hold_cnt == c_max_hold);
   assign w_release    = (r_state == OWNED) && !bus.hwait &&
                         (w_owner_last || !w_owner_req || w_watchdog);

   // The releasing owner sits out this round so someone else gets a turn.
   assign w_mask = w_release ? r_grant : '0;
   assign w_take = w_found && ((r_state == IDLE) || w_release);

   arb_pick #(
      .MASTER_NUM (MASTER_NUM),
      .PRIOR_BIT  (PRIOR_BIT)
   ) u_pick (
      .req    (bus.hreq),
      .mask   (w_mask),
      .start  (r_rr_ptr),
      .prior  (bus.hprior),
      .mode   (ARB_MODE),
      .found  (w_found),
      .winner (w_winner)
   );

   assign w_winner_oh = {{(MASTER_NUM-1){1'b0}}, 1'b1} << w_winner;
   assign w_ptr_after = (w_winner == c_last_idx) ? '0 : (w_winner + 1'b1);

   always_comb begin : p_next
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant;
      w_hsel_nxt     = r_hsel;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_hold_cnt_nxt = r_hold_cnt;
      // A burst end or abort coinciding with the watchdog is not a forced release.
      w_hforce_nxt   = w_release && w_watchdog && w_owner_req && !w_owner_last;

      if (w_take) begin
         w_state_nxt    = OWNED;
         w_grant_nxt    = w_winner_oh;
         w_hsel_nxt     = 1'b1;
         w_hold_cnt_nxt = c_hw'(1);
         if (ARB_MODE != ARB_FIXED) begin
            w_rr_ptr_nxt = w_ptr_after;
         end
      end else if (w_release) begin
         w_state_nxt    = IDLE;
         w_grant_nxt    = '0;
         w_hsel_nxt     = 1'b0;
         w_hold_cnt_nxt = '0;
      end else if ((r_state == OWNED) && !bus.hwait && (r_hold_cnt < c_max_hold)) begin
         w_hold_cnt_nxt = r_hold_cnt + 1'b1;
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin : p_regs
      if (hreset) begin
         r_state    <= IDLE;
         r_grant    <= '0;
         r_hsel     <= 1'b0;
         r_hforce   <= 1'b0;
         r_rr_ptr   <= '0;
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_hsel     <= w_hsel_nxt;
         r_hforce   <= w_hforce_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_hold_cnt <= w_hold_cnt_nxt;
      end
   end

   assign bus.hgrant  = r_grant;
   assign bus.hmaster = c_iw'(onehot2idx(16'(r_grant)));
   assign bus.hsel    = r_hsel;
   assign bus.hforce  = r_hforce;

endmodule

`default_nettype wire

// File: tb/tb_ahb_slave_arbiter.sv
//----------------------------------------------------------------------------
// Module  : tb_ahb_slave_arbiter
// Brief   : Scoreboard bench for four arbiter configurations (RR, FIXED, DYN, no watchdog).
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_ahb_slave_arbiter
   import ahb_slave_arbiter_pkg::*;
;

   typedef struct {
      int         inst;
      logic [3:0] grant;
      logic       frc;
      string      tag;
   } exp_t;

   logic       hclk;
   logic       hreset;
   logic [3:0] s_req   [4];
   logic [3:0] s_last  [4];
   logic       s_wait  [4];
   logic [7:0] s_prior [4];
   logic [3:0] ob_grant  [4];
   logic [1:0] ob_master [4];
   logic       ob_sel    [4];
   logic       ob_frc    [4];

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_total = 0;
   int   n_bad   = 0;

   ahb_slave_arbiter_if #(.MASTER_NUM(4), .PRIOR_BIT(2)) u_if0 ();
   ahb_slave_arbiter_if #(.MASTER_NUM(4), .PRIOR_BIT(2)) u_if1 ();
   ahb_slave_arbiter_if #(.MASTER_NUM(4), .PRIOR_BIT(2)) u_if2 ();
   ahb_slave_arbiter_if #(.MASTER_NUM(4), .PRIOR_BIT(2)) u_if3 ();

   ahb_slave_arbiter #(.MASTER_NUM(4), .PRIOR_BIT(2), .ARB_MODE(ARB_RR),    .MAX_HOLD(8))
      u_dut0 (.hclk(hclk), .hreset(hreset), .bus(u_if0.slave));
   ahb_slave_arbiter #(.MASTER_NUM(4), .PRIOR_BIT(2), .ARB_MODE(ARB_FIXED), .MAX_HOLD(8))
      u_dut1 (.hclk(hclk), .hreset(hreset), .bus(u_if1.slave));
   ahb_slave_arbiter #(.MASTER_NUM(4), .PRIOR_BIT(2), .ARB_MODE(ARB_DYN),   .MAX_HOLD(8))
      u_dut2 (.hclk(hclk), .hreset(hreset), .bus(u_if2.slave));
   ahb_slave_arbiter #(.MASTER_NUM(4), .PRIOR_BIT(2), .ARB_MODE(ARB_RR),    .MAX_HOLD(0))
      u_dut3 (.hclk(hclk), .hreset(hreset), .bus(u_if3.slave));

   assign u_if0.hreq = s_req[0];  assign u_if0.hlast = s_last[0];
   assign u_if0.hwait = s_wait[0]; assign u_if0.hprior = s_prior[0];
   assign u_if1.hreq = s_req[1];  assign u_if1.hlast = s_last[1];
   assign u_if1.hwait = s_wait[1]; assign u_if1.hprior = s_prior[1];
   assign u_if2.hreq = s_req[2];  assign u_if2.hlast = s_last[2];
   assign u_if2.hwait = s_wait[2]; assign u_if2.hprior = s_prior[2];
   assign u_if3.hreq = s_req[3];  assign u_if3.hlast = s_last[3];
   assign u_if3.hwait = s_wait[3]; assign u_if3.hprior = s_prior[3];

   assign ob_grant[0] = u_if0.hgrant; assign ob_master[0] = u_if0.hmaster;
   assign ob_sel[0]   = u_if0.hsel;   assign ob_frc[0]    = u_if0.hforce;
   assign ob_grant[1] = u_if1.hgrant; assign ob_master[1] = u_if1.hmaster;
   assign ob_sel[1]   = u_if1.hsel;   assign ob_frc[1]    = u_if1.hforce;
   assign ob_grant[2] = u_if2.hgrant; assign ob_master[2] = u_if2.hmaster;
   assign ob_sel[2]   = u_if2.hsel;   assign ob_frc[2]    = u_if2.hforce;
   assign ob_grant[3] = u_if3.hgrant; assign ob_master[3] = u_if3.hmaster;
   assign ob_sel[3]   = u_if3.hsel;   assign ob_frc[3]    = u_if3.hforce;

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] idx_of(input logic [3:0] g);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (g[i]) r = 2'(i);
      end
      return r;
   endfunction

   // Drive one cycle of inputs and queue what the outputs must show after the edge.
   task automatic step(input int inst, input logic [3:0] req, input logic [3:0] last,
                       input logic wt, input logic [3:0] eg, input logic ef, input string tag);
      exp_t e;
      @(negedge hclk);
      s_req[inst]  = req;
      s_last[inst] = last;
      s_wait[inst] = wt;
      e.inst  = inst;
      e.grant = eg;
      e.frc   = ef;
      e.tag   = tag;
      sb_q.push_back(e);
   endtask

   task automatic chk_idle(input string tag);
      chk_val({tag, ".grant"},  32'(ob_grant[0]),  32'h0);
      chk_val({tag, ".sel"},    32'(ob_sel[0]),    32'h0);
      chk_val({tag, ".master"}, 32'(ob_master[0]), 32'h0);
      chk_val({tag, ".force"},  32'(ob_frc[0]),    32'h0);
   endtask

   always @(posedge hclk) begin
      #1;
      if (sb_q.size() != 0) begin
         mon_e = sb_q.pop_front();
         chk_val({mon_e.tag, ".grant"}, 32'(ob_grant[mon_e.inst]), 32'(mon_e.grant));
         chk_val({mon_e.tag, ".sel"},   32'(ob_sel[mon_e.inst]),   32'(|mon_e.grant));
         if (|mon_e.grant) begin
            chk_val({mon_e.tag, ".master"}, 32'(ob_master[mon_e.inst]), 32'(idx_of(mon_e.grant)));
         end
         chk_val({mon_e.tag, ".force"}, 32'(ob_frc[mon_e.inst]), 32'(mon_e.frc));
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, expected finish before 100000");
      $fatal(1, "timeout");
   end

   initial begin
      hreset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_req[i] = '0; s_last[i] = '0; s_wait[i] = 1'b0; s_prior[i] = '0;
      end
      s_prior[2] = 8'h3D;
      @(negedge hclk);
      @(negedge hclk);
      chk_idle("reset");
      hreset = 1'b0;

      // Rotating order with 2-beat bursts and direct handover; M3 wraps back to M0.
      step(0, 4'b1111, 4'b0000, 0, 4'b0001, 0, "rr1");
      step(0, 4'b1111, 4'b0000, 0, 4'b0001, 0, "rr2");
      step(0, 4'b1111, 4'b0001, 0, 4'b0010, 0, "rr3");
      step(0, 4'b1111, 4'b0000, 0, 4'b0010, 0, "rr4");
      step(0, 4'b1111, 4'b0010, 0, 4'b0100, 0, "rr5");
      step(0, 4'b1111, 4'b0000, 0, 4'b0100, 0, "rr6");
      step(0, 4'b1111, 4'b0100, 0, 4'b1000, 0, "rr7");
      step(0, 4'b1111, 4'b0000, 0, 4'b1000, 0, "rr8");
      step(0, 4'b1111, 4'b1000, 0, 4'b0001, 0, "rr9");
      step(0, 4'b1111, 4'b0000, 0, 4'b0001, 0, "rr10");
      step(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, "rr11");

      // Fixed priority: M1 holds three beats, then M3.
      step(1, 4'b1010, 4'b0000, 0, 4'b0010, 0, "fx1");
      step(1, 4'b1010, 4'b0000, 0, 4'b0010, 0, "fx2");
      step(1, 4'b1010, 4'b0000, 0, 4'b0010, 0, "fx3");
      step(1, 4'b1010, 4'b0010, 0, 4'b1000, 0, "fx4");
      step(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, "fx5");

      // Dynamic priority: M1/M2 tie at 3, M0 at 1.
      step(2, 4'b0111, 4'b0000, 0, 4'b0010, 0, "dy1");
      step(2, 4'b0111, 4'b0010, 0, 4'b0100, 0, "dy2");
      step(2, 4'b0101, 4'b0000, 0, 4'b0100, 0, "dy3");
      step(2, 4'b0001, 4'b0000, 0, 4'b0001, 0, "dy4");
      step(2, 4'b0000, 4'b0000, 0, 4'b0000, 0, "dy5");

      // Slave wait freezes the grant across hlast.
      step(0, 4'b0001, 4'b0000, 0, 4'b0001, 0, "wt1");
      step(0, 4'b0011, 4'b0000, 1, 4'b0001, 0, "wt2");
      for (int k = 0; k < 4; k++) step(0, 4'b0011, 4'b0001, 1, 4'b0001, 0, "wt3");
      step(0, 4'b0011, 4'b0001, 0, 4'b0010, 0, "wt4");
      step(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, "wt5");

      // Watchdog revokes M2 after 8 grant cycles.
      for (int k = 0; k < 8; k++) step(0, 4'b1100, 4'b0000, 0, 4'b0100, 0, "wd_hold");
      step(0, 4'b1100, 4'b0000, 0, 4'b1000, 1, "wd_fire");
      step(0, 4'b1100, 4'b0000, 0, 4'b1000, 0, "wd_after");
      step(0, 4'b1100, 4'b1000, 0, 4'b0100, 0, "wd_back");
      step(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, "wd_end");

      // hlast on the watchdog cycle is a normal release; owner may re-win next round.
      for (int k = 0; k < 8; k++) step(1, 4'b0100, 4'b0000, 0, 4'b0100, 0, "wl_hold");
      step(1, 4'b0100, 4'b0100, 0, 4'b0000, 0, "wl_rel");
      step(1, 4'b0100, 4'b0000, 0, 4'b0100, 0, "wl_again");
      step(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, "wl_end");

      // Watchdog disabled: M2 keeps the grant.
      for (int k = 0; k < 20; k++) step(3, 4'b1100, 4'b0000, 0, 4'b0100, 0, "nowd");
      step(3, 4'b0000, 4'b0000, 0, 4'b0000, 0, "nowd_end");

      // Asynchronous reset in the middle of an M2 burst.
      step(0, 4'b0100, 4'b0000, 0, 4'b0100, 0, "rs1");
      step(0, 4'b0100, 4'b0000, 0, 4'b0100, 0, "rs2");
      @(negedge hclk);
      #2;
      hreset = 1'b1;
      #1;
      chk_idle("rs_async");
      s_req[0] = 4'b0000;
      @(negedge hclk);
      hreset = 1'b0;
      step(0, 4'b1001, 4'b0000, 0, 4'b0001, 0, "rs_ptr0");
      step(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, "rs_drop");
      step(0, 4'b0100, 4'b0000, 0, 4'b0100, 0, "rs_lat");
      step(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, "rs_end");

      @(negedge hclk);
      chk_val("sb_drain", 32'(sb_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ahb_slave_arbiter.md
Name: ahb_slave_arbiter

Overview:
- Parametrised per-slave AHB arbiter: the next generation of the slave-0 arbiter, generalised to N masters with a selectable arbitration mode.
- Sits in front of each generated slave port. Takes master requests, burst-end (hlast) and slave wait, and issues a registered one-hot grant that is held for a whole burst.
- Adds round-robin fairness, dynamic-priority tie-breaking, back-to-back handover and a hold watchdog that forces release of a stuck master.

Parameters:
- MASTER_NUM, 4, number of requesting masters (2..16).
- PRIOR_BIT, 2, width of each master's dynamic priority field.
- ARB_MODE, ARB_RR, arbitration mode: ARB_FIXED (lowest index wins), ARB_RR (rotating), ARB_DYN (highest hprior wins; ties broken round-robin).
- MAX_HOLD, 16, maximum grant length in cycles before forced release; 0 disables the watchdog.

Ports:
- hclk  in  1  system clock; all logic on the rising edge.
- hreset  in  1  asynchronous, active-high reset.
- hreq  in  MASTER_NUM  per-master request.
- hlast  in  MASTER_NUM  per-master last-beat-of-burst flag.
- hwait  in  1  slave stall; freezes arbitration.
- hprior  in  MASTER_NUM*PRIOR_BIT  packed per-master priority; ignored unless ARB_MODE==ARB_DYN.
- hgrant  out  MASTER_NUM  registered one-hot grant.
- hmaster  out  $clog2(MASTER_NUM)  index of the granted master; valid while hsel=1.
- hsel  out  1  registered; equals |hgrant.
- hforce  out  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (asynchronous, hreset=1): hgrant=0, hmaster=0, hsel=0, hforce=0, state=IDLE, rr_ptr=0, hold_cnt=0.
- State IDLE:
  - If |hreq, compute winner W combinationally.
  - Next edge: hgrant=onehot(W), hmaster=W, hsel=1, state=OWNED, hold_cnt=1.
  - Latency from request to grant is 1 cycle.
  - If hreq is all zero, remain in IDLE with outputs 0.
- State OWNED, grant holds while any of the following is true:
  - hwait=1: highest precedence; hold_cnt also freezes.
  - hreq[owner]=1 and hlast[owner]=0.
- Release events, evaluated only when hwait=0:
  - (a) hlast[owner]=1: normal burst end.
  - (b) hreq[owner]=0: abort.
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD: watchdog. Also pulses hforce=1 on the following cycle.
- On release:
  - Arbitrate in the same cycle among hreq with the owner's bit masked off.
  - If another requester exists, the grant moves directly to it on the next edge: no idle cycle, hold_cnt=1.
  - If none, the next state is IDLE with hgrant=0.
  - The masked owner may re-win only in the following arbitration round.
- Simultaneous events: hlast and the watchdog in the same cycle count as a normal release, with hforce=0. hwait=1 together with hlast defers the release until the first cycle with hwait=0 while hlast is still asserted.
- ARB_RR: search starts at rr_ptr and wraps modulo MASTER_NUM. On each new grant, rr_ptr=(W+1)%MASTER_NUM; from MASTER_NUM-1 it wraps to 0.
- ARB_DYN:
  - Select the maximum hprior among requesters.
  - Break ties with the rr_ptr search; rr_ptr is updated as in ARB_RR.
  - hprior is sampled only at arbitration instants.
- ARB_FIXED: rr_ptr is unused.
- hold_cnt saturates at MAX_HOLD.
- Invariants: hgrant is always one-hot or zero; hsel==|hgrant; hmaster==index(hgrant) when hsel=1.
- Reset asserted mid-burst: all outputs clear immediately (asynchronously); no handover occurs.

Decomposition:
- arbiter_package additions:
  - enum arb_mode_e {ARB_FIXED, ARB_RR, ARB_DYN}.
  - state enum arb_state_e {IDLE, OWNED}.
  - Default constants for MASTER_NUM, PRIOR_BIT and MAX_HOLD.
  - function onehot2idx.
- One sub-module, arb_pick: combinational rotating-priority picker.
  - Inputs: req, mask, start pointer, prior, mode.
  - Outputs: found and winner index.
  - Instantiated once.
- The top level holds the FSM, rr_ptr, hold_cnt and the output registers.

Test Plan (MASTER_NUM=4, PRIOR_BIT=2, MAX_HOLD=8 unless stated):
- ARB_RR, hreq=4'b1111 constant, each master asserts hlast on its 2nd granted beat -> grant order M0,M1,M2,M3,M0; every handover has no idle cycle; rr_ptr wraps from 3 to 0.
- ARB_FIXED, hreq=4'b1010; M1 bursts 3 beats with hlast on beat 3 -> hgrant=0010 for exactly 3 cycles, then 1000 the next cycle.
- ARB_DYN, hreq=4'b0111, hprior={M2=3, M1=3, M0=1}, rr_ptr=0 -> M1 wins first, M2 wins next; M0 is granted only after both drop their requests.
- hwait=1 held for 5 cycles, covering the cycle where M0 asserts hlast -> hgrant=0001 stays stable; release happens on the first cycle with hwait=0 and hlast=1.
- Watchdog: M2 holds hreq=1 with hlast=0 for 20 cycles while M3 requests -> after 8 grant cycles hgrant moves to 1000 and hforce pulses 1 for exactly one cycle. Repeat with MAX_HOLD=0 -> M2 keeps the grant indefinitely.
- Assert hreset mid-burst while hgrant=0100 -> hgrant, hsel, hmaster and hforce are 0 in the same cycle. After deassert with hreq=4'b0100 -> grant returns 1 cycle later; rr_ptr restarts at 0.
